// File: rtl/repl_policy_array.sv
// ---------------------------------------------------------------------------
// repl_policy_array
//
// Per-set replacement state for a set-associative cache. Each set holds either
// true-LRU age counters (POLICY=0, one $clog2(ASSOC)-bit age per way, ages form
// a permutation of 0..ASSOC-1, age ASSOC-1 = LRU) or a tree-PLRU bit vector
// (POLICY=1, ASSOC-1 bits in heap order: node n has children 2n+1 / 2n+2,
// bit 0 points left toward the lower ways, 1 points right).
//
// After reset or init_req the array sweeps one set per cycle to its initial
// state; commands are accepted only once ready is high.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   init_req       pulse: re-initialise every set
//   ready          sweep complete, commands accepted
//   lkp_valid      victim lookup request
//   lkp_index      set to look up
//   lkp_valid_mask per-way valid bits of that set
//   vic_valid      victim result valid (one cycle after an accepted lookup)
//   vic_way        selected victim way
//   upd_valid      update request
//   upd_op         01 touch (make MRU), 10 demote (make LRU), others ignored
//   upd_index      set to update
//   upd_way        way to update
// ---------------------------------------------------------------------------
module repl_policy_array #(
    parameter int ASSOC      = 8,
    parameter int INDEX_SIZE = 7,
    parameter int POLICY     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_req,
    output logic                     ready,
    input  logic                     lkp_valid,
    input  logic [INDEX_SIZE-1:0]    lkp_index,
    input  logic [ASSOC-1:0]         lkp_valid_mask,
    output logic                     vic_valid,
    output logic [$clog2(ASSOC)-1:0] vic_way,
    input  logic                     upd_valid,
    input  logic [1:0]               upd_op,
    input  logic [INDEX_SIZE-1:0]    upd_index,
    input  logic [$clog2(ASSOC)-1:0] upd_way
);

    localparam int SETS  = 2 ** INDEX_SIZE;
    localparam int WAY_W = $clog2(ASSOC);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [INDEX_SIZE-1:0]   sweep_q, sweep_d;
    logic                    sweep_we;
    logic                    lkp_acc;
    logic                    upd_acc;
    logic                    same_set;
    logic [WAY_W-1:0]        victim;

    assign ready    = (state_q == ST_READY);
    assign lkp_acc  = ready && lkp_valid;
    assign upd_acc  = ready && upd_valid && (upd_op == 2'b01 || upd_op == 2'b10);
    // A lookup to the set being updated this cycle sees the post-update state.
    assign same_set = upd_acc && (upd_index == lkp_index);

    function automatic logic [WAY_W-1:0] first_invalid(input logic [ASSOC-1:0] mask);
        logic [WAY_W-1:0] v;
        v = '0;
        for (int i = ASSOC - 1; i >= 0; i--) begin
            if (!mask[WAY_W'(i)]) v = WAY_W'(i);
        end
        return v;
    endfunction

    // -----------------------------------------------------------------------
    // Control FSM: INIT sweeps sets 0..SETS-1, then READY.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        sweep_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                sweep_we = 1'b1;
                if (init_req) begin
                    sweep_d = '0;
                end else if (sweep_q == INDEX_SIZE'(SETS - 1)) begin
                    state_d = ST_READY;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_READY: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            sweep_q   <= '0;
            vic_valid <= 1'b0;
            vic_way   <= '0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            vic_valid <= lkp_acc;
            if (lkp_acc) vic_way <= victim;
        end
    end

    // -----------------------------------------------------------------------
    // Policy storage and next-state logic
    // -----------------------------------------------------------------------
    generate
        if (POLICY == 0) begin : g_age
            localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(ASSOC - 1);
            typedef logic [ASSOC-1:0][WAY_W-1:0] ages_t;

            ages_t age_mem [SETS];
            ages_t upd_cur, upd_next, lkp_cur;

            function automatic ages_t age_init();
                ages_t r;
                for (int i = 0; i < ASSOC; i++) r[WAY_W'(i)] = WAY_W'(i);
                return r;
            endfunction

            // Touch: younger ways age by one, w becomes 0.
            // Demote: older ways get one younger, w becomes the oldest.
            function automatic ages_t age_update(input ages_t cur, input logic demote,
                                                 input logic [WAY_W-1:0] w);
                ages_t r;
                logic [WAY_W-1:0] aw;
                aw = cur[w];
                for (int i = 0; i < ASSOC; i++) begin
                    r[WAY_W'(i)] = cur[WAY_W'(i)];
                    if (WAY_W'(i) == w)
                        r[WAY_W'(i)] = demote ? AGE_MAX : '0;
                    else if (!demote && cur[WAY_W'(i)] < aw)
                        r[WAY_W'(i)] = cur[WAY_W'(i)] + 1'b1;
                    else if (demote && cur[WAY_W'(i)] > aw)
                        r[WAY_W'(i)] = cur[WAY_W'(i)] - 1'b1;
                end
                return r;
            endfunction

            function automatic logic [WAY_W-1:0] age_victim(input ages_t cur);
                logic [WAY_W-1:0] v;
                v = '0;
                for (int i = 0; i < ASSOC; i++) begin
                    if (cur[WAY_W'(i)] == AGE_MAX) v = WAY_W'(i);
                end
                return v;
            endfunction

            always_comb begin
                upd_cur  = age_mem[upd_index];
                upd_next = age_update(upd_cur, upd_op[1], upd_way);
                lkp_cur  = same_set ? upd_next : age_mem[lkp_index];
                victim   = (&lkp_valid_mask) ? age_victim(lkp_cur)
                                             : first_invalid(lkp_valid_mask);
            end

            always_ff @(posedge clk) begin
                if (sweep_we)
                    age_mem[sweep_q] <= age_init();
                else if (upd_acc)
                    age_mem[upd_index] <= upd_next;
            end
        end else begin : g_plru
            localparam int PLRU_W = ASSOC - 1;
            typedef logic [PLRU_W-1:0] tree_t;

            tree_t plru_mem [SETS];
            tree_t upd_cur, upd_next, lkp_cur;

            // Walk w's root-to-leaf path; touch points each node away from w,
            // demote points it toward w. The path bit at level l is w's MSB-first bit l.
            function automatic tree_t plru_update(input tree_t cur, input logic demote,
                                                  input logic [WAY_W-1:0] w);
                tree_t r, bit_sel;
                logic [WAY_W-1:0] s;
                logic dir;
                int node;
                r    = cur;
                node = 0;
                for (int l = 0; l < WAY_W; l++) begin
                    s       = w >> (WAY_W - 1 - l);
                    dir     = s[0];
                    bit_sel = tree_t'(1) << node;
                    if (demote ? dir : !dir) r = r | bit_sel;
                    else                     r = r & ~bit_sel;
                    node = 2 * node + 1 + int'(dir);
                end
                return r;
            endfunction

            function automatic logic [WAY_W-1:0] plru_victim(input tree_t cur);
                logic [WAY_W-1:0] v;
                tree_t t;
                int node;
                v    = '0;
                node = 0;
                for (int l = 0; l < WAY_W; l++) begin
                    t    = cur >> node;
                    v    = (v << 1) | WAY_W'(t[0]);
                    node = 2 * node + 1 + int'(t[0]);
                end
                return v;
            endfunction

            always_comb begin
                upd_cur  = plru_mem[upd_index];
                upd_next = plru_update(upd_cur, upd_op[1], upd_way);
                lkp_cur  = same_set ? upd_next : plru_mem[lkp_index];
                victim   = (&lkp_valid_mask) ? plru_victim(lkp_cur)
                                             : first_invalid(lkp_valid_mask);
            end

            always_ff @(posedge clk) begin
                if (sweep_we)
                    plru_mem[sweep_q] <= '0;
                else if (upd_acc)
                    plru_mem[upd_index] <= upd_next;
            end
        end
    endgenerate

endmodule

// File: tb/tb_repl_policy_array.sv
// ---------------------------------------------------------------------------
// tb_repl_policy_array
//
// Drives an age-mode and a PLRU-mode instance (ASSOC=4, 4 sets) with the same
// stimulus. The reference keeps, per set, a recency list (MRU first) for the
// age policy and a bisection-tree bit array for PLRU.
// ---------------------------------------------------------------------------
module tb_repl_policy_array;

    localparam int A    = 4;
    localparam int IW   = 2;
    localparam int SETS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_req = 1'b0;
    logic       lkp_valid = 1'b0;
    logic [1:0] lkp_index = '0;
    logic [3:0] lkp_valid_mask = 4'hF;
    logic       upd_valid = 1'b0;
    logic [1:0] upd_op = '0;
    logic [1:0] upd_index = '0;
    logic [1:0] upd_way = '0;

    logic       a_ready, a_vic_valid;
    logic [1:0] a_vic_way;
    logic       p_ready, p_vic_valid;
    logic [1:0] p_vic_way;

    int checks = 0;
    int failures = 0;

    int m_order [SETS][A];
    bit m_tree  [SETS][A-1];
    bit m_ready = 1'b0;

    always #5 clk = ~clk;

    repl_policy_array #(.ASSOC(A), .INDEX_SIZE(IW), .POLICY(0)) u_age (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(a_ready),
        .lkp_valid(lkp_valid), .lkp_index(lkp_index), .lkp_valid_mask(lkp_valid_mask),
        .vic_valid(a_vic_valid), .vic_way(a_vic_way),
        .upd_valid(upd_valid), .upd_op(upd_op), .upd_index(upd_index), .upd_way(upd_way)
    );

    repl_policy_array #(.ASSOC(A), .INDEX_SIZE(IW), .POLICY(1)) u_plru (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(p_ready),
        .lkp_valid(lkp_valid), .lkp_index(lkp_index), .lkp_valid_mask(lkp_valid_mask),
        .vic_valid(p_vic_valid), .vic_way(p_vic_way),
        .upd_valid(upd_valid), .upd_op(upd_op), .upd_index(upd_index), .upd_way(upd_way)
    );

    // ---------------- reference model ----------------
    function automatic void m_init();
        for (int s = 0; s < SETS; s++) begin
            for (int i = 0; i < A; i++) m_order[s][i] = i;
            for (int k = 0; k < A - 1; k++) m_tree[s][k] = 1'b0;
        end
    endfunction

    function automatic void m_age_update(int s, int w, bit demote);
        int p = 0;
        for (int i = 0; i < A; i++) if (m_order[s][i] == w) p = i;
        if (!demote) begin
            for (int j = p; j > 0; j--) m_order[s][j] = m_order[s][j-1];
            m_order[s][0] = w;
        end else begin
            for (int j = p; j < A - 1; j++) m_order[s][j] = m_order[s][j+1];
            m_order[s][A-1] = w;
        end
    endfunction

    function automatic void m_plru_update(int s, int w, bit demote);
        int lo = 0, hi = A, k = 0, mid;
        bit right;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            right = (w >= mid);
            m_tree[s][k] = demote ? right : !right;
            if (right) begin lo = mid; k = 2 * k + 2; end
            else       begin hi = mid; k = 2 * k + 1; end
        end
    endfunction

    function automatic int m_first_invalid(logic [3:0] m);
        for (int i = 0; i < A; i++) if (!m[i]) return i;
        return -1;
    endfunction

    function automatic int m_age_victim(int s, logic [3:0] m);
        int fi = m_first_invalid(m);
        if (fi >= 0) return fi;
        return m_order[s][A-1];
    endfunction

    function automatic int m_plru_victim(int s, logic [3:0] m);
        int fi = m_first_invalid(m);
        int lo = 0, hi = A, k = 0, mid;
        if (fi >= 0) return fi;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_tree[s][k]) begin lo = mid; k = 2 * k + 2; end
            else              begin hi = mid; k = 2 * k + 1; end
        end
        return lo;
    endfunction

    // One clock of stimulus; returns the expected result of that edge.
    task automatic do_cycle(input bit lv, input int li, input logic [3:0] lm,
                            input bit uv, input int uop, input int ui, input int uw,
                            output bit ev, output int ea, output int ep);
        lkp_valid      = lv;
        lkp_index      = 2'(li);
        lkp_valid_mask = lm;
        upd_valid      = uv;
        upd_op         = 2'(uop);
        upd_index      = 2'(ui);
        upd_way        = 2'(uw);
        @(posedge clk);
        #1;
        ev = 1'b0; ea = 0; ep = 0;
        if (m_ready) begin
            if (uv && (uop == 1 || uop == 2)) begin
                m_age_update(ui, uw, uop == 2);
                m_plru_update(ui, uw, uop == 2);
            end
            if (lv) begin
                ev = 1'b1;
                ea = m_age_victim(li, lm);
                ep = m_plru_victim(li, lm);
            end
        end
        lkp_valid = 1'b0;
        upd_valid = 1'b0;
    endtask

    // Count cycles until ready rises (expected 4), issuing ignored traffic.
    task automatic wait_ready(input string name);
        int n = 0;
        while (a_ready !== 1'b1 && n < 20) begin
            lkp_valid      = 1'b1;
            lkp_index      = 2'($urandom_range(0, 3));
            lkp_valid_mask = 4'hF;
            upd_valid      = 1'b1;
            upd_op         = 2'b01;
            upd_index      = 2'($urandom_range(0, 3));
            upd_way        = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            n++;
            if (a_ready !== 1'b1) begin
                checks++;
                if (a_vic_valid !== 1'b0 || p_vic_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_vic_valid_in_sweep: got a=%0b p=%0b expected 0", name, a_vic_valid, p_vic_valid);
                end
            end
        end
        lkp_valid = 1'b0;
        upd_valid = 1'b0;
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL %s_ready_cycles: got %0d expected 4", name, n);
        end
        checks++;
        if (p_ready !== 1'b1 || a_vic_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_edge: got p_ready=%0b a_vic_valid=%0b expected 1/0", name, p_ready, a_vic_valid);
        end
        m_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        lkp_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_ready !== 1'b0 || p_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got a=%0b p=%0b expected 0", a_ready, p_ready);
        end
        checks++;
        if (a_vic_valid !== 1'b0 || p_vic_valid !== 1'b0 || a_vic_way !== 2'd0 || p_vic_way !== 2'd0) begin
            failures++;
            $display("FAIL reset_vic: got valid=%0b/%0b way=%0d/%0d expected 0", a_vic_valid, p_vic_valid, a_vic_way, p_vic_way);
        end
        lkp_valid = 1'b0;
        m_init();
        m_ready = 1'b0;
        rst_n = 1'b1;
        wait_ready("reset");
    endtask

    task automatic test_age_basic();
        bit ev; int ea, ep;
        do_cycle(1, 0, 4'hF, 0, 0, 0, 0, ev, ea, ep);
        checks++;
        if (a_vic_valid !== 1'b1 || a_vic_way !== 2'd3) begin
            failures++;
            $display("FAIL age_init_lookup: got valid=%0b way=%0d expected 1/3", a_vic_valid, a_vic_way);
        end
        checks++;
        if (p_vic_valid !== 1'b1 || p_vic_way !== 2'(ep)) begin
            failures++;
            $display("FAIL plru_init_lookup: got valid=%0b way=%0d expected 1/%0d", p_vic_valid, p_vic_way, ep);
        end
        do_cycle(0, 0, 4'hF, 0, 0, 0, 0, ev, ea, ep);
        checks++;
        if (a_vic_valid !== 1'b0 || p_vic_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_vic_valid: got a=%0b p=%0b expected 0", a_vic_valid, p_vic_valid);
        end
        do_cycle(0, 0, 4'hF, 1, 1, 1, 3, ev, ea, ep);
        do_cycle(1, 1, 4'hF, 0, 0, 0, 0, ev, ea, ep);
        checks++;
        if (a_vic_valid !== 1'b1 || a_vic_way !== 2'd2) begin
            failures++;
            $display("FAIL age_touch_lookup: got valid=%0b way=%0d expected 1/2", a_vic_valid, a_vic_way);
        end
    endtask

    task automatic test_mask();
        bit ev; int ea, ep;
        do_cycle(1, 2, 4'b1011, 0, 0, 0, 0, ev, ea, ep);
        checks++;
        if (a_vic_way !== 2'd2 || p_vic_way !== 2'd2) begin
            failures++;
            $display("FAIL mask_1011: got a=%0d p=%0d expected 2", a_vic_way, p_vic_way);
        end
        do_cycle(1, 2, 4'b0000, 0, 0, 0, 0, ev, ea, ep);
        checks++;
        if (a_vic_way !== 2'd0 || p_vic_way !== 2'd0) begin
            failures++;
            $display("FAIL mask_0000: got a=%0d p=%0d expected 0", a_vic_way, p_vic_way);
        end
    endtask

    task automatic test_forward();
        bit ev; int ea, ep;
        do_cycle(1, 1, 4'hF, 1, 1, 1, 2, ev, ea, ep);
        checks++;
        if (a_vic_valid !== 1'b1 || a_vic_way !== 2'd1) begin
            failures++;
            $display("FAIL fwd_same_set: got valid=%0b way=%0d expected 1/1", a_vic_valid, a_vic_way);
        end
        checks++;
        if (p_vic_way !== 2'(ep)) begin
            failures++;
            $display("FAIL fwd_same_set_plru: got %0d expected %0d", p_vic_way, ep);
        end
        do_cycle(1, 3, 4'hF, 1, 1, 1, 3, ev, ea, ep);
        checks++;
        if (a_vic_way !== 2'd3) begin
            failures++;
            $display("FAIL fwd_other_set: got %0d expected 3", a_vic_way);
        end
    endtask

    task automatic test_init_traffic();
        bit ev; int ea, ep;
        init_req  = 1'b1;
        upd_valid = 1'b1;
        upd_op    = 2'b01;
        upd_index = 2'd1;
        upd_way   = 2'd1;
        @(posedge clk);
        #1;
        init_req  = 1'b0;
        upd_valid = 1'b0;
        m_init();
        m_ready = 1'b0;
        checks++;
        if (a_ready !== 1'b0 || p_ready !== 1'b0) begin
            failures++;
            $display("FAIL init_req_ready: got a=%0b p=%0b expected 0", a_ready, p_ready);
        end
        wait_ready("init_req");
        do_cycle(1, 1, 4'hF, 0, 0, 0, 0, ev, ea, ep);
        checks++;
        if (a_vic_valid !== 1'b1 || a_vic_way !== 2'd3) begin
            failures++;
            $display("FAIL post_init_lookup: got valid=%0b way=%0d expected 1/3", a_vic_valid, a_vic_way);
        end
    endtask

    task automatic test_plru();
        bit ev; int ea, ep;
        do_cycle(1, 0, 4'hF, 0, 0, 0, 0, ev, ea, ep);
        checks++;
        if (p_vic_way !== 2'd0) begin
            failures++;
            $display("FAIL plru_fresh: got %0d expected 0", p_vic_way);
        end
        do_cycle(0, 0, 4'hF, 1, 1, 0, 0, ev, ea, ep);
        do_cycle(0, 0, 4'hF, 1, 1, 0, 2, ev, ea, ep);
        do_cycle(1, 0, 4'hF, 0, 0, 0, 0, ev, ea, ep);
        checks++;
        if (p_vic_way !== 2'd1) begin
            failures++;
            $display("FAIL plru_touch: got %0d expected 1", p_vic_way);
        end
        checks++;
        if (a_vic_way !== 2'(ea)) begin
            failures++;
            $display("FAIL plru_touch_age: got %0d expected %0d", a_vic_way, ea);
        end
        do_cycle(0, 0, 4'hF, 1, 2, 0, 3, ev, ea, ep);
        do_cycle(1, 0, 4'hF, 0, 0, 0, 0, ev, ea, ep);
        checks++;
        if (p_vic_way !== 2'd3 || a_vic_way !== 2'(ea)) begin
            failures++;
            $display("FAIL plru_demote: got p=%0d a=%0d expected 3/%0d", p_vic_way, a_vic_way, ea);
        end
    endtask

    task automatic test_reset_mid_sweep();
        init_req = 1'b1;
        @(posedge clk);
        #1;
        init_req = 1'b0;
        m_init();
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (a_ready !== 1'b0 || a_vic_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_state: got ready=%0b vic_valid=%0b expected 0", a_ready, a_vic_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready("mid_reset");
    endtask

    task automatic test_random();
        bit ev; int ea, ep;
        bit lv, uv;
        int li, ui, uw, uop;
        logic [3:0] lm;
        for (int c = 0; c < 400; c++) begin
            lv  = ($urandom_range(0, 3) != 0);
            li  = $urandom_range(0, 3);
            lm  = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            uv  = ($urandom_range(0, 2) != 0);
            uop = $urandom_range(0, 3);
            ui  = ($urandom_range(0, 1) != 0) ? li : $urandom_range(0, 3);
            uw  = $urandom_range(0, 3);
            do_cycle(lv, li, lm, uv, uop, ui, uw, ev, ea, ep);
            checks++;
            if (a_vic_valid !== ev || p_vic_valid !== ev) begin
                failures++;
                $display("FAIL rand_valid[%0d]: got a=%0b p=%0b expected %0b", c, a_vic_valid, p_vic_valid, ev);
            end
            if (ev) begin
                checks++;
                if (a_vic_way !== 2'(ea)) begin
                    failures++;
                    $display("FAIL rand_age_way[%0d]: got %0d expected %0d", c, a_vic_way, ea);
                end
                checks++;
                if (p_vic_way !== 2'(ep)) begin
                    failures++;
                    $display("FAIL rand_plru_way[%0d]: got %0d expected %0d", c, p_vic_way, ep);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_age_basic();
        test_mask();
        test_forward();
        test_init_traffic();
        test_plru();
        test_reset_mid_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/repl_policy_array.md
Name: repl_policy_array

Overview:
- Per-set replacement-state store for the set-associative cache core. Supersedes the fixed-ASSOC true-LRU array.
- Selectable policy: true-LRU age counters or tree-PLRU.
- Invalid-way-first victim selection, registered victim lookup, and touch/demote update ports.
- Self-initialising sweep after reset or on flush.
- Sits beside tag/data arrays; driven by the cache controller FSM.

Parameters:
- ASSOC, 8, ways per set; power of 2, >=2.
- INDEX_SIZE, 7, set index width; SETS = 2**INDEX_SIZE.
- POLICY, 0, 0 = true-LRU age counters, 1 = tree-PLRU (ASSOC-1 bits per set).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_req  in  1  pulse: re-initialise all sets.
- ready  out  1  high when sweep complete and commands accepted.
- lkp_valid  in  1  victim lookup request.
- lkp_index  in  INDEX_SIZE  set to look up.
- lkp_valid_mask  in  ASSOC  per-way valid bits of that set from tag array.
- vic_valid  out  1  victim result valid.
- vic_way  out  $clog2(ASSOC)  selected victim way.
- upd_valid  in  1  update request.
- upd_op  in  2  01 touch (make MRU), 10 demote (make LRU); 00/11 ignored.
- upd_index  in  INDEX_SIZE  set to update.
- upd_way  in  $clog2(ASSOC)  way to update.

Behaviour:
- Reset (rst_n low, async): FSM=INIT, sweep counter=0, ready=0, vic_valid=0, vic_way=0.
- FSM INIT:
  - Writes one set per cycle at the sweep counter.
  - Age mode: way i age = i, so way ASSOC-1 is LRU.
  - PLRU mode: all tree bits = 0.
  - After set SETS-1 is written, next cycle FSM=READY, ready=1. ready stays low for exactly SETS cycles after reset release.
- FSM READY: init_req=1 -> INIT, counter=0, ready=0 next cycle. init_req during INIT restarts the sweep from 0.
- Commands while ready=0: lkp_valid and upd_valid are ignored; vic_valid held 0. rst_n low mid-sweep restarts the sweep.
- Lookup: lkp_valid at edge N -> vic_valid=1 and vic_way at edge N+1 (1-cycle latency, registered). vic_valid=0 in cycles with no accepted lookup.
- Victim selection, priority order:
  - If any lkp_valid_mask bit is 0: lowest-index invalid way.
  - Else age mode: the way whose age == ASSOC-1.
  - Else PLRU mode: walk tree from root. Bit 0 = go left (lower ways), 1 = go right.
- Age touch (way w): every way with age < age[w] increments; age[w] <- 0; other ways unchanged.
- Age demote (way w): every way with age > age[w] decrements; age[w] <- ASSOC-1.
- Ages always remain a permutation of 0..ASSOC-1.
- PLRU touch (way w): each bit on w's root-to-leaf path is set to point away from w.
- PLRU demote (way w): each bit on w's path is set to point toward w.
- Update commits at the edge it is presented; 1 update per cycle.
- Same-cycle hazard: lkp_index == upd_index with both valid -> victim computed from post-update state (write-first forwarding). Different indices are independent.
- Lookup and update never stall; no backpressure.

Test Plan:
- ASSOC=4, INDEX_SIZE=2, POLICY=0: release rst_n -> ready=0 for 4 cycles, then 1. lookup set 0 with mask 4'b1111 -> vic_valid one cycle later, vic_way=3.
- Age mode: touch set1 way3, then lookup set1 mask 4'b1111 -> vic_way=2; internal ages way0..3 = 1,2,3,0.
- Age mode: lookup set2 mask 4'b1011 -> vic_way=2 regardless of ages. Mask 4'b0000 -> vic_way=0.
- Age mode: same cycle touch set1 way2 and lookup set1 -> vic_way=1 (forwarded). Same cycle touch set1 way3 and lookup set3 -> vic_way=3.
- POLICY=1: after init lookup set0 -> vic_way 0. Touch way0, touch way2, lookup -> vic_way=1. Demote way3, lookup -> vic_way=3.
- init_req pulse while traffic is flowing -> ready=0 for 4 cycles, vic_valid stays 0 for lookups issued then. After ready=1, lookup set1 -> vic_way=3 (age mode). rst_n asserted mid-sweep -> sweep restarts, 4 more ready=0 cycles.
